// File: rtl/im_fetch_port.sv
// im_fetch_port: handshaked big-endian instruction memory with fixed read latency and byte load port.
// Define IM_MISALIGN_CHECK_EN to also fault fetches whose address is not word aligned.
module im_fetch_port #(
  parameter int MEM_BYTES = 128,
  parameter int LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_instr_o,
  output logic        rsp_err_o,
  input  logic        load_en_i,
  input  logic [31:0] load_addr_i,
  input  logic [7:0]  load_data_i,
  output logic        busy_o
);
  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] instr_q;
  logic        err_q;
  logic        valid_q;
  logic        busy_q;
  logic [7:0]  mem_q [MEM_BYTES];
  logic [AW-1:0] idx;
  logic        accept;
  logic        range_err;
  logic        err_d;
  logic [31:0] instr_d;
  assign idx       = req_addr_i[AW-1:0];
  assign range_err = req_addr_i > 32'(MEM_BYTES - 4);
`ifdef IM_MISALIGN_CHECK_EN
  assign err_d = range_err || (req_addr_i[1:0] != 2'b00);
`else
  assign err_d = range_err;
`endif
  // Index wrap on faulting addresses is harmless: the word is forced to zero.
  assign instr_d = err_d ? 32'h0 : {mem_q[idx], mem_q[idx + AW'(1)], mem_q[idx + AW'(2)], mem_q[idx + AW'(3)]};
  assign req_ready_o = (state_q == IDLE) && !load_en_i;
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_valid_o = valid_q;
  assign rsp_instr_o = instr_q;
  assign rsp_err_o   = err_q;
  assign busy_o      = busy_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      instr_q <= 32'h0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          instr_q <= instr_d;
          err_q   <= err_d;
          busy_q  <= 1'b1;
          if (LATENCY > 1) begin
            state_q <= WAIT;
            cnt_q   <= 4'(LATENCY - 1);
          end else begin
            state_q <= RESP;
            valid_q <= 1'b1;
          end
        end
        WAIT: if (cnt_q == 4'd1) begin
          state_q <= RESP;
          valid_q <= 1'b1;
          cnt_q   <= 4'd0;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        RESP: if (rsp_ready_i) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  // Storage deliberately has no reset so a program survives rst_n.
  always_ff @(posedge clk) begin
    if (load_en_i && (load_addr_i < 32'(MEM_BYTES))) mem_q[load_addr_i[AW-1:0]] <= load_data_i;
  end
endmodule
